// File: rtl/paralelo_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : paralelo_serial_if
//  Description : Byte handshake and serial line bundle for the byte-to-bit
//                transmitter. The slave modport is the transmitter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface paralelo_serial_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             data_out;
    logic             active_out;

    // Byte source side: offers bytes, watches the line and status.
    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  active_out
    );

    // Transmitter side.
    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output active_out
    );
endinterface
`default_nettype wire

// File: rtl/paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : paralelo_serial
//  Description : Byte-to-bit serial transmitter. Sends MIN_COMMAS comma
//                characters after reset for receiver alignment, then sends
//                offered bytes (or COMMA when none is offered), MSB first,
//                one bit per clk_32f cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module paralelo_serial #(
    parameter int               WIDTH      = 8,      // only 8 is supported
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               MIN_COMMAS = 4       // legal range 1..15
) (
    input  wire logic        clk_32f,
    input  wire logic        reset,
    paralelo_serial_if.slave bus
);

    typedef enum logic [0:0] {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // comma_cnt value at which the alignment run ends.
    localparam logic [3:0] LAST_COMMA = 4'(MIN_COMMAS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_nxt;
    logic [3:0]       comma_cnt;
    logic [3:0]       comma_cnt_nxt;
    logic [WIDTH-1:0] cur_byte;
    logic [WIDTH-1:0] cur_byte_nxt;
    logic             ser_bit;
    logic             ser_bit_nxt;
    logic             at_boundary;
    logic             ready;

    // Byte boundary and the Moore "next byte is chosen now" decode.
    assign at_boundary = (bit_cnt == 3'd7);
    assign ready       = at_boundary && ((state == ACTIVE) || (comma_cnt == LAST_COMMA));

    assign bus.ready_out  = ready;
    assign bus.active_out = (state == ACTIVE);
    assign bus.data_out   = ser_bit;

    // Next-state logic: shift out the current bit and reload at the boundary.
    always_comb begin
        state_nxt     = state;
        comma_cnt_nxt = comma_cnt;
        cur_byte_nxt  = cur_byte;
        bit_cnt_nxt   = bit_cnt + 3'd1;
        // ~bit_cnt equals 7-bit_cnt for a 3-bit counter: MSB goes first.
        ser_bit_nxt   = cur_byte[~bit_cnt];

        if (at_boundary) begin
            if (ready) begin
                // End of alignment or normal operation: take the offered byte,
                // fall back to COMMA so the line never carries an undefined byte.
                state_nxt    = ACTIVE;
                cur_byte_nxt = bus.valid_in ? bus.data_in : COMMA;
            end else begin
                // Still inside the alignment run.
                comma_cnt_nxt = comma_cnt + 4'd1;
                cur_byte_nxt  = COMMA;
            end
        end
    end

    // State register; reset abandons any partial byte and restarts alignment.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= SYNC;
            bit_cnt   <= 3'd0;
            comma_cnt <= 4'd0;
            cur_byte  <= COMMA;
            ser_bit   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
            cur_byte  <= cur_byte_nxt;
            ser_bit   <= ser_bit_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paralelo_serial
//  Description : Self-checking bench for paralelo_serial. Two instances
//                (MIN_COMMAS=4 and MIN_COMMAS=1) share stimulus; a bit-stream
//                model predicts the line, ready_out and active_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paralelo_serial;

    localparam logic [7:0] COMMA = 8'hBC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    paralelo_serial_if #(.WIDTH(8)) bus0 ();
    paralelo_serial_if #(.WIDTH(8)) bus1 ();

    paralelo_serial #(.WIDTH(8), .COMMA(COMMA), .MIN_COMMAS(4)) dut0 (
        .clk_32f (clk),
        .reset   (rst),
        .bus     (bus0.slave)
    );

    paralelo_serial #(.WIDTH(8), .COMMA(COMMA), .MIN_COMMAS(1)) dut1 (
        .clk_32f (clk),
        .reset   (rst),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    // Model: per instance, the bits still owed to the line (oldest at the top
    // of the valid region), plus the "has chosen a user slot" flag.
    logic [63:0] pend [2];
    int          plen [2];
    logic        act  [2];
    int          mins [2] = '{4, 1};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic tick(input logic r, input logic v, input logic [7:0] d);
        logic exp_bit [2];
        logic obs_d [2];
        logic obs_r [2];
        logic obs_a [2];
        rst            = r;
        bus0.valid_in  = v;
        bus0.data_in   = d;
        bus1.valid_in  = v;
        bus1.data_in   = d;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                exp_bit[i] = 1'b0;
                act[i]     = 1'b0;
                plen[i]    = 0;
                pend[i]    = '0;
                for (int k = 0; k < mins[i]; k++) begin
                    pend[i] = (pend[i] << 8) | 64'(COMMA);
                    plen[i] += 8;
                end
            end else begin
                // One bit left before this edge means this edge picks the next byte.
                logic was_ready;
                was_ready  = (plen[i] == 1);
                exp_bit[i] = pend[i][plen[i]-1];
                plen[i]--;
                if (was_ready) begin
                    pend[i] = (pend[i] << 8) | 64'(v ? d : COMMA);
                    plen[i] += 8;
                    act[i]  = 1'b1;
                end
            end
        end
        #1;
        obs_d[0] = bus0.data_out;  obs_r[0] = bus0.ready_out;  obs_a[0] = bus0.active_out;
        obs_d[1] = bus1.data_out;  obs_r[1] = bus1.ready_out;  obs_a[1] = bus1.active_out;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d.data_out", i),   8'(obs_d[i]), 8'(exp_bit[i]));
            check($sformatf("i%0d.ready_out", i),  8'(obs_r[i]), 8'(plen[i] == 1));
            check($sformatf("i%0d.active_out", i), 8'(obs_a[i]), 8'(act[i]));
        end
    endtask

    // Idle with (hv,hd) until instance 0 reaches a ready cycle, then offer (v,d).
    task automatic boundary(input logic v, input logic [7:0] d,
                            input logic hv, input logic [7:0] hd);
        int n = 0;
        while (plen[0] != 1 && n < 64) begin
            tick(1'b0, hv, hd);
            n++;
        end
        if (n >= 64) check("ready_bound", 8'(n), 8'd0);
        tick(1'b0, v, d);
    endtask

    initial begin
        bus0.valid_in = 1'b0;  bus0.data_in = 8'h00;
        bus1.valid_in = 1'b0;  bus1.data_in = 8'h00;

        // Reset, then the alignment run with nothing offered.
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        boundary(1'b0, 8'h00, 1'b0, 8'h00);

        // Two user bytes at successive slots, then idle.
        boundary(1'b1, 8'hFF, 1'b0, 8'h00);
        boundary(1'b1, 8'hEE, 1'b0, 8'h00);
        boundary(1'b0, 8'h00, 1'b0, 8'h00);

        // Offer held only outside the ready cycle must never reach the line.
        boundary(1'b0, 8'h00, 1'b1, 8'hA5);
        boundary(1'b0, 8'h00, 1'b1, 8'hA5);
        boundary(1'b0, 8'h00, 1'b0, 8'h00);

        // Mid-byte reset while 0xFF is on the line, then realign.
        boundary(1'b1, 8'hFF, 1'b0, 8'h00);
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        boundary(1'b0, 8'h00, 1'b0, 8'h00);

        // Back-to-back bytes including a user byte equal to COMMA.
        boundary(1'b1, 8'h01, 1'b0, 8'h00);
        boundary(1'b1, 8'h80, 1'b0, 8'h00);
        boundary(1'b1, 8'hBC, 1'b0, 8'h00);
        boundary(1'b0, 8'h00, 1'b0, 8'h00);

        // Random traffic with occasional resets.
        repeat (2000) begin
            tick(($urandom_range(0, 120) == 0), 1'($urandom), 8'($urandom));
        end
        repeat (16) tick(1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
